tile_spawn_controller: RTL and testbench

- Sits directly downstream of the random new-block generator and upstream of the board register file.
- On a spawn request after a completed move, it builds the 16-bit empty-cell mask from the current board and presents it to the generator.
- It accepts the generator's position and 2/4 choice, then issues exactly one board write of the new tile.
- A bounded retry counter with a deterministic fallback guarantees the write completes; a full board is reported instead of written.

---
 rtl/game_2048_pkg.sv | 32 +++
 rtl/lowest_set_index.sv | 24 ++
 rtl/tile_spawn_controller.sv | 121 ++++++++++++
 tb/tb_tile_spawn_controller.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_2048_pkg.sv
// Shared constants and types for the 2048 board datapath.
// Cell i of a packed board occupies bits [4i+3:4i] and holds a tile exponent.
package game_2048_pkg;

   localparam int N_CELLS = 16;
   localparam int CELL_W  = 4;
   localparam int BOARD_W = N_CELLS * CELL_W;
   localparam int IDX_W   = $clog2(N_CELLS);

   localparam logic [CELL_W-1:0] EXP_EMPTY = 4'd0;
   localparam logic [CELL_W-1:0] EXP_TWO   = 4'd1;
   localparam logic [CELL_W-1:0] EXP_FOUR  = 4'd2;

   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      WAIT,
      WRITE,
      FULL
   } spawn_state_t;

   // Bit i is set when cell i holds the empty exponent.
   function automatic logic [N_CELLS-1:0] empty_mask(input logic [BOARD_W-1:0] board);
      logic [N_CELLS-1:0] mask;
      mask = '0;
      for (int i = 0; i < N_CELLS; i++) begin
         mask[i] = (board[i*CELL_W +: CELL_W] == EXP_EMPTY);
      end
      return mask;
   endfunction

endpackage

// File: rtl/lowest_set_index.sv
// Combinational priority encoder: index of the lowest set bit of a cell mask.
// valid is low when the mask is all zero (index is then 0).
module lowest_set_index
   import game_2048_pkg::*;
(
   input  logic [N_CELLS-1:0] mask,
   output logic [IDX_W-1:0]   index,
   output logic               valid
);

   always_comb begin
      // NOTE: every output gets a default before the loop so no path can infer a latch.
      index = '0;
      valid = 1'b0;
      // Walk downward so the lowest set bit is the last one to assign.
      for (int i = N_CELLS - 1; i >= 0; i--) begin
         if (mask[i]) begin
            index = IDX_W'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tile_spawn_controller.sv
// Places one new tile per request: scans the board for empty cells, accepts a
// qualified generator choice or falls back to the lowest empty cell, then writes it once.
module tile_spawn_controller
   import game_2048_pkg::*;
#(
   parameter  int MAX_TRIES = 32,
   localparam int TRY_W     = $clog2(MAX_TRIES)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               spawn_req,
   input  logic [BOARD_W-1:0] board_in,
   input  logic               gen_done,
   input  logic [IDX_W-1:0]   gen_pos,
   input  logic               gen_four,
   output logic [N_CELLS-1:0] gen_mask,
   output logic               wr_en,
   output logic [IDX_W-1:0]   wr_addr,
   output logic [CELL_W-1:0]  wr_val,
   output logic               busy,
   output logic               spawn_done,
   output logic               board_full
);

   spawn_state_t       state;
   logic [TRY_W-1:0]   tries;
   logic [IDX_W-1:0]   fallback_addr;

   logic [N_CELLS-1:0] scan_mask;
   logic [IDX_W-1:0]   scan_lowest;
   logic               scan_any;
   logic               accept;
   logic               last_try;

   assign scan_mask = empty_mask(board_in);

   // Encoding the live board during SCAN yields the same answer as encoding the
   // latched mask later, and keeps the encoder off the WAIT-state decision path.
   lowest_set_index u_lowest (
      .mask  (scan_mask),
      .index (scan_lowest),
      .valid (scan_any)
   );

   // The generator's word alone is not trusted: the cell must be empty in our own mask.
   assign accept   = gen_done && gen_mask[gen_pos];
   assign last_try = (tries == TRY_W'(MAX_TRIES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         tries         <= '0;
         fallback_addr <= '0;
         gen_mask      <= '0;
         wr_en         <= 1'b0;
         wr_addr       <= '0;
         wr_val        <= EXP_EMPTY;
         busy          <= 1'b0;
         spawn_done    <= 1'b0;
         board_full    <= 1'b0;
      end else begin
         // NOTE: state is updated with non-blocking assignments so every register
         // samples pre-edge values, independent of statement order.
         wr_en      <= 1'b0;
         spawn_done <= 1'b0;

         case (state)
            IDLE: begin
               if (spawn_req) begin
                  state      <= SCAN;
                  busy       <= 1'b1;
                  board_full <= 1'b0;
               end
            end

            SCAN: begin
               gen_mask      <= scan_mask;
               fallback_addr <= scan_lowest;
               tries         <= '0;
               if (scan_any) begin
                  state <= WAIT;
               end else begin
                  state      <= FULL;
                  board_full <= 1'b1;
                  spawn_done <= 1'b1;
               end
            end

            WAIT: begin
               // Accept is tested first so it wins over a coincident final try.
               if (accept) begin
                  state      <= WRITE;
                  wr_addr    <= gen_pos;
                  wr_val     <= gen_four ? EXP_FOUR : EXP_TWO;
                  wr_en      <= 1'b1;
                  spawn_done <= 1'b1;
               end else if (last_try) begin
                  state      <= WRITE;
                  wr_addr    <= fallback_addr;
                  wr_val     <= EXP_TWO;
                  wr_en      <= 1'b1;
                  spawn_done <= 1'b1;
               end else begin
                  tries <= tries + 1'b1;
               end
            end

            WRITE, FULL: begin
               state <= IDLE;
               busy  <= 1'b0;
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tile_spawn_controller.sv
// Self-checking bench: table of spawn scenarios scored through an expected-result
// queue, plus hand sequences for candidate cycling, dropped requests and async reset.
module tb_tile_spawn_controller;
   import game_2048_pkg::*;

   localparam int MAX    = 8;
   localparam int BUDGET = MAX + 20;

   logic        clk = 1'b0;
   logic        rst;
   logic        spawn_req;
   logic [63:0] board_in;
   logic        gen_done;
   logic [3:0]  gen_pos;
   logic        gen_four;
   logic [15:0] gen_mask;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [3:0]  wr_val;
   logic        busy;
   logic        spawn_done;
   logic        board_full;

   typedef struct {
      logic       wr;
      logic [3:0] addr;
      logic [3:0] val;
      logic       full;
   } exp_t;

   typedef struct {
      logic [63:0] board;
      logic        done;
      logic [3:0]  pos;
      logic        four;
      exp_t        e;
      logic [15:0] mask;
      int          lat;
   } vec_t;

   exp_t sb[$];
   int   checks   = 0;
   int   errors   = 0;
   int   wr_count = 0;

   tile_spawn_controller #(.MAX_TRIES(MAX)) dut (
      .clk        (clk),
      .rst        (rst),
      .spawn_req  (spawn_req),
      .board_in   (board_in),
      .gen_done   (gen_done),
      .gen_pos    (gen_pos),
      .gen_four   (gen_four),
      .gen_mask   (gen_mask),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_val     (wr_val),
      .busy       (busy),
      .spawn_done (spawn_done),
      .board_full (board_full)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Completion monitor: every wr_en or spawn_done pulse must match the oldest expectation.
   always @(posedge clk) begin
      #1;
      if (rst && (wr_en || spawn_done)) begin
         if (wr_en) wr_count++;
         if (sb.size() == 0) begin
            check("unexpected_completion", {63'd0, wr_en | spawn_done}, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("mon_spawn_done", spawn_done, 1'b1);
            check("mon_wr_en", wr_en, e.wr);
            check("mon_board_full", board_full, e.full);
            if (e.wr) begin
               check("mon_wr_addr", wr_addr, e.addr);
               check("mon_wr_val", wr_val, e.val);
            end
         end
      end
   end

   // Called just after a rising edge; returns just after a rising edge.
   task automatic run_spawn(input string name, input vec_t v, input logic cycle_pos);
      int   lat;
      logic seen;
      board_in  = v.board;
      gen_done  = v.done;
      gen_pos   = v.pos;
      gen_four  = v.four;
      sb.push_back(v.e);
      spawn_req = 1'b1;
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < BUDGET) begin
         @(posedge clk);
         #1;
         lat++;
         spawn_req = 1'b0;
         if (lat == 1) begin
            check({name, "_busy_start"}, busy, 1'b1);
            check({name, "_full_cleared"}, board_full, 1'b0);
         end
         if (lat == 2) board_in = ~v.board;
         if (spawn_done) seen = 1'b1;
         else if (cycle_pos) gen_pos = gen_pos + 4'd1;
      end
      check({name, "_latency"}, lat, v.lat);
      check({name, "_mask"}, gen_mask, v.mask);
      @(posedge clk);
      #1;
      check({name, "_busy_after"}, busy, 1'b0);
      check({name, "_done_single"}, {spawn_done, wr_en}, 2'b00);
      check({name, "_full_sticky"}, board_full, v.e.full);
   endtask

   initial begin
      vec_t vecs[9];
      vec_t v;
      int   base;
      int   lat;
      logic seen;

      vecs[0] = '{64'h0, 1'b1, 4'd5, 1'b0, '{1'b1, 4'd5, 4'd1, 1'b0}, 16'hFFFF, 3};
      vecs[1] = '{64'h1111_1101_1111_1111, 1'b1, 4'd9, 1'b1, '{1'b1, 4'd9, 4'd2, 1'b0}, 16'h0200, 3};
      vecs[2] = '{64'h5555_0222_3330_4444, 1'b0, 4'd0, 1'b0, '{1'b1, 4'd4, 4'd1, 1'b0}, 16'h0810, MAX + 2};
      vecs[3] = '{64'h1234_5678_9ABC_DEF1, 1'b1, 4'd0, 1'b1, '{1'b0, 4'd0, 4'd0, 1'b1}, 16'h0000, 2};
      vecs[4] = '{64'h0, 1'b1, 4'd0, 1'b1, '{1'b1, 4'd0, 4'd2, 1'b0}, 16'hFFFF, 3};
      vecs[5] = '{64'h0111_1111_1111_1111, 1'b0, 4'd0, 1'b0, '{1'b1, 4'd15, 4'd1, 1'b0}, 16'h8000, MAX + 2};
      vecs[6] = '{64'h2222_2222_0000_0000, 1'b1, 4'd6, 1'b1, '{1'b1, 4'd6, 4'd2, 1'b0}, 16'h00FF, 3};
      vecs[7] = '{64'h0000_0000_0000_0001, 1'b1, 4'd0, 1'b1, '{1'b1, 4'd1, 4'd1, 1'b0}, 16'hFFFE, MAX + 2};
      vecs[8] = '{64'hFFFF_FFFF_FFFF_FF0F, 1'b1, 4'd1, 1'b0, '{1'b1, 4'd1, 4'd1, 1'b0}, 16'h0002, 3};

      rst       = 1'b0;
      spawn_req = 1'b0;
      board_in  = '0;
      gen_done  = 1'b0;
      gen_pos   = '0;
      gen_four  = 1'b0;
      #2;
      check("reset_outputs", {gen_mask, wr_en, wr_addr, wr_val, busy, spawn_done, board_full}, 33'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("idle_busy", busy, 1'b0);

      foreach (vecs[i]) begin
         run_spawn($sformatf("vec%0d", i), vecs[i], 1'b0);
      end

      // Only cell 9 empty; candidate walks 0..15, positions 2..8 (incl. 3) are rejected.
      v = '{64'h1111_1101_1111_1111, 1'b1, 4'd0, 1'b1, '{1'b1, 4'd9, 4'd2, 1'b0}, 16'h0200, 10};
      run_spawn("cycle_pos", v, 1'b1);

      // Requests during WAIT and during the completion cycle are dropped.
      board_in  = '0;
      gen_done  = 1'b0;
      base      = wr_count;
      sb.push_back('{1'b1, 4'd0, 4'd1, 1'b0});
      spawn_req = 1'b1;
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < BUDGET) begin
         @(posedge clk);
         #1;
         lat++;
         spawn_req = (lat == 4);
         if (spawn_done) seen = 1'b1;
      end
      check("drop_latency", lat, MAX + 2);
      spawn_req = 1'b1;
      @(posedge clk);
      #1;
      spawn_req = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      check("drop_busy_idle", busy, 1'b0);
      check("drop_one_write", wr_count - base, 1);

      // Asynchronous reset while waiting aborts with no write.
      base      = wr_count;
      spawn_req = 1'b1;
      repeat (4) begin
         @(posedge clk);
         #1;
         spawn_req = 1'b0;
      end
      check("pre_reset_busy", busy, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      check("async_reset_outputs", {gen_mask, wr_en, wr_addr, wr_val, busy, spawn_done, board_full}, 33'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (MAX + 6) begin
         @(posedge clk);
         #1;
      end
      check("reset_no_write", wr_count - base, 0);
      check("reset_busy_idle", busy, 1'b0);

      v = '{64'h1111_1111_1111_0011, 1'b1, 4'd3, 1'b0, '{1'b1, 4'd3, 4'd1, 1'b0}, 16'h000C, 3};
      run_spawn("after_reset", v, 1'b0);

      check("scoreboard_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
